// File: rtl/dmem_responder.sv
// Data-memory responder: owns the core's data RAM, answers each bus request after
// a fixed wait with a one-cycle dm_rdy pulse, and exposes a preload port for idle cycles.
module dmem_responder #(
  parameter int N           = 32,
  parameter int DM_AB       = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dm_re,
  input  logic             dm_we,
  input  logic [DM_AB-1:0] dm_ad,
  input  logic [N-1:0]     dm_d,
  output logic [N-1:0]     dm_q,
  output logic             dm_rdy,
  output logic             dm_err,
  input  logic             ld_valid,
  input  logic [DM_AB-1:0] ld_addr,
  input  logic [N-1:0]     ld_data,
  output logic             ld_ready
);

  localparam int         DEPTH = 2 ** DM_AB;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [DM_AB-1:0]   ad_q, ad_d;
  logic [N-1:0]       d_q, d_d;
  logic [N-1:0]       q_q, q_d;
  logic               err_q, err_d;
  logic [N-1:0]       mem [DEPTH];
  logic [N-1:0]       rd_word;

  assign rd_word = mem[ad_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ad_d    = ad_q;
    d_d     = d_q;
    q_d     = q_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (dm_re | dm_we) begin
          // A simultaneous read+write is resolved as a write and flagged.
          we_d    = dm_we;
          ad_d    = dm_ad;
          d_d     = dm_d;
          cnt_d   = WC;
          err_d   = err_q | (dm_re & dm_we);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (!we_q) q_d = rd_word;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ad_q    <= '0;
      d_q     <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ad_q    <= ad_d;
      d_q     <= d_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  // RAM is never cleared; a write committing in RESP lands even on a reset edge.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q)
      mem[ad_q] <= d_q;
    else if (ld_valid && ld_ready)
      mem[ld_addr] <= ld_data;
  end

  assign dm_rdy   = (state_q == S_RESP);
  assign dm_q     = (state_q == S_RESP && !we_q) ? rd_word : q_q;
  assign dm_err   = err_q;
  assign ld_ready = (state_q == S_IDLE) & ~dm_re & ~dm_we;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 1, 0 and 3.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam int WCS [NI] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        re    [NI];
  logic        we    [NI];
  logic [7:0]  ad    [NI];
  logic [31:0] d     [NI];
  logic [31:0] q     [NI];
  logic        rdy   [NI];
  logic        err   [NI];
  logic        ldv   [NI];
  logic [7:0]  lda   [NI];
  logic [31:0] ldd   [NI];
  logic        ldr   [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rdy = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    dmem_responder #(
      .N(32), .DM_AB(8), .WAIT_CYCLES((i == 0) ? 1 : ((i == 1) ? 0 : 3))
    ) u_dut (
      .clk(clk), .rst(rst[i]),
      .dm_re(re[i]), .dm_we(we[i]), .dm_ad(ad[i]), .dm_d(d[i]),
      .dm_q(q[i]), .dm_rdy(rdy[i]), .dm_err(err[i]),
      .ld_valid(ldv[i]), .ld_addr(lda[i]), .ld_data(ldd[i]), .ld_ready(ldr[i])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one core request, hold it until dm_rdy, then drop it and step into IDLE.
  task automatic req(input int k, input logic r, input logic w, input logic [7:0] a,
                     input logic [31:0] dd, output logic [31:0] qo);
    int lat;
    re[k] = r; we[k] = w; ad[k] = a; d[k] = dd;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rdy[k] && lat < 40);
    chk("latency", 32'(lat), 32'(WCS[k] + 1));
    qo = q[k];
    last_rdy = cyc;
    re[k] = 1'b0; we[k] = 1'b0;
    tick();
    chk("rdy_one_cycle", {31'd0, rdy[k]}, 32'd0);
  endtask

  task automatic wr(input int k, input logic [7:0] a, input logic [31:0] dd);
    logic [31:0] qo;
    req(k, 1'b0, 1'b1, a, dd, qo);
  endtask

  task automatic rd(input int k, input logic [7:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] qo;
    req(k, 1'b1, 1'b0, a, 32'h0, qo);
    chk(tag, qo, exp);
  endtask

  task automatic load(input int k, input logic [7:0] a, input logic [31:0] dd);
    ldv[k] = 1'b1; lda[k] = a; ldd[k] = dd;
    #1;
    chk("ld_ready_idle", {31'd0, ldr[k]}, 32'd1);
    @(posedge clk); #1; cyc++;
    ldv[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] qo;
    int c0;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; re[i] = 1'b0; we[i] = 1'b0; ad[i] = '0; d[i] = '0;
      ldv[i] = 1'b0; lda[i] = '0; ldd[i] = '0;
    end
    tick(); tick();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_rdy", {31'd0, rdy[i]}, 32'd0);
      chk("reset_q",   q[i], 32'd0);
      chk("reset_err", {31'd0, err[i]}, 32'd0);
    end

    // T1: WAIT_CYCLES=1 write then read back
    wr(0, 8'h10, 32'hDEADBEEF);
    rd(0, 8'h10, 32'hDEADBEEF, "t1_readback");

    // T2: WAIT_CYCLES=0 alternating, extreme addresses
    wr(1, 8'h00, 32'hAAAA0000);
    c0 = last_rdy;
    wr(1, 8'hFF, 32'h5555FFFF);
    chk("t2_rdy_spacing", 32'(last_rdy - c0), 32'd2);
    c0 = last_rdy;
    rd(1, 8'h00, 32'hAAAA0000, "t2_read_00");
    chk("t2_rdy_spacing_rd", 32'(last_rdy - c0), 32'd2);
    rd(1, 8'hFF, 32'h5555FFFF, "t2_read_ff");

    // T3: load port fill, then core read; load blocked while core requests
    load(0, 8'h00, 32'd1);
    load(0, 8'h01, 32'd2);
    load(0, 8'h02, 32'd3);
    load(0, 8'h03, 32'd4);
    rd(0, 8'h02, 32'd3, "t3_read_2");
    ldv[0] = 1'b1; lda[0] = 8'h03; ldd[0] = 32'h99;
    re[0] = 1'b1; ad[0] = 8'h01;
    #1;
    chk("t3_ld_ready_blocked", {31'd0, ldr[0]}, 32'd0);
    req(0, 1'b1, 1'b0, 8'h01, 32'h0, qo);
    ldv[0] = 1'b0;
    chk("t3_read_1", qo, 32'd2);
    rd(0, 8'h03, 32'd4, "t3_ram_unchanged");

    // T4: simultaneous re/we behaves as write and sets sticky error
    req(0, 1'b1, 1'b1, 8'h20, 32'h5, qo);
    chk("t4_err_set", {31'd0, err[0]}, 32'd1);
    rd(0, 8'h20, 32'h5, "t4_written");
    chk("t4_err_sticky", {31'd0, err[0]}, 32'd1);
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; #1;
    chk("t4_err_cleared", {31'd0, err[0]}, 32'd0);

    // T5: WAIT_CYCLES=3, reset during WAIT drops the write
    wr(2, 8'h30, 32'h1234);
    we[2] = 1'b1; ad[2] = 8'h30; d[2] = 32'hA;
    tick();
    chk("t5_no_rdy_w1", {31'd0, rdy[2]}, 32'd0);
    tick();
    chk("t5_no_rdy_w2", {31'd0, rdy[2]}, 32'd0);
    we[2] = 1'b0; rst[2] = 1'b1;
    tick();
    chk("t5_no_rdy_rst", {31'd0, rdy[2]}, 32'd0);
    rst[2] = 1'b0;
    #1;
    chk("t5_idle_after_rst", {31'd0, ldr[2]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rdy_after", {31'd0, rdy[2]}, 32'd0);
    end
    rd(2, 8'h30, 32'h1234, "t5_prior_value");

    // T6: dm_q holds read data through a write response
    wr(0, 8'h40, 32'h7);
    rd(0, 8'h40, 32'h7, "t6_read_40");
    chk("t6_q_hold_idle", q[0], 32'h7);
    req(0, 1'b0, 1'b1, 8'h41, 32'h9, qo);
    chk("t6_q_in_wr_resp", qo, 32'h7);
    chk("t6_q_after_wr", q[0], 32'h7);
    rd(0, 8'h41, 32'h9, "t6_read_41");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
